// File: rtl/jtframe_bank_rd_slots_pkg.sv
// Shared constants for the two-slot SDRAM read front end: FSM encoding and
// 16/32-bit word selection.
package jtframe_bank_rd_slots_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] WAIT_RDY = 2'd2;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = 32;

  // Odd word addresses live in the upper half of the 32-bit line.
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic              odd);
    return odd ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/jtframe_rd_line_cache.sv
// One-line (32-bit) read cache for a single slot: tag/valid, hit compare and
// registered ok/dout.
module jtframe_rd_line_cache
  import jtframe_bank_rd_slots_pkg::*;
#(
  parameter int unsigned AW = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [AW-1:0]     addr,
  input  logic              cs,
  input  logic              fill,
  input  logic [AW-2:0]     fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  output logic              hit,
  output logic              ok,
  output logic [WORD_W-1:0] dout
);

  logic [AW-2:0]     tag_q;
  logic [LINE_W-1:0] line_q;
  logic              valid_q;
  logic              ok_q;
  logic [WORD_W-1:0] dout_q;
  logic              fill_match;
  logic [LINE_W-1:0] eff_line;

  assign hit        = valid_q && (tag_q == addr[AW-1:1]);
  // Forward the incoming fill so ok rises the cycle right after rdy.
  assign fill_match = fill && (fill_tag == addr[AW-1:1]);
  assign eff_line   = fill_match ? fill_data : line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (clr) begin
        valid_q <= 1'b0;
      end else if (fill) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag;
        line_q  <= fill_data;
      end
      ok_q <= cs && !clr && (hit || fill_match);
      if (cs && (hit || fill_match)) begin
        dout_q <= word_sel(eff_line, addr[0]);
      end
    end
  end

  assign ok   = ok_q;
  assign dout = dout_q;

endmodule

// File: rtl/jtframe_bank_rd_slots.sv
// Two-client read front end for one read-only SDRAM bank port: per-slot line
// caches, round-robin miss arbitration and a single rd/ack/rdy transaction.
module jtframe_bank_rd_slots
  import jtframe_bank_rd_slots_pkg::*;
#(
  parameter int unsigned   AW      = 22,
  parameter logic [AW-1:0] OFFSET0 = '0,
  parameter logic [AW-1:0] OFFSET1 = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [AW-1:0]     slot0_addr,
  input  logic              slot0_cs,
  output logic              slot0_ok,
  output logic [WORD_W-1:0] slot0_dout,
  input  logic [AW-1:0]     slot1_addr,
  input  logic              slot1_cs,
  output logic              slot1_ok,
  output logic [WORD_W-1:0] slot1_dout,
  output logic [AW-1:0]     ba_addr,
  output logic              ba_rd,
  input  logic              ba_ack,
  input  logic              ba_rdy,
  input  logic [LINE_W-1:0] ba_dout
);

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic [AW-2:0] tag_q, tag_d;
  logic          ba_rd_q, ba_rd_d;
  logic [AW-1:0] ba_addr_q, ba_addr_d;
  logic          ptr_q, ptr_d;
  logic          discard_q, discard_d;
  logic          fill, fill_keep;
  logic          pick;
  logic          hit0, hit1, miss0, miss1;

  assign miss0 = slot0_cs && !hit0;
  assign miss1 = slot1_cs && !hit1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tag_d     = tag_q;
    ba_rd_d   = ba_rd_q;
    ba_addr_d = ba_addr_q;
    ptr_d     = ptr_q;
    discard_d = discard_q;
    fill      = 1'b0;
    pick      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clr && (miss0 || miss1)) begin
          pick = (miss0 && miss1) ? ptr_q : miss1;
          if (miss0 && miss1) ptr_d = ~ptr_q;
          sel_d     = pick;
          tag_d     = pick ? slot1_addr[AW-1:1] : slot0_addr[AW-1:1];
          ba_rd_d   = 1'b1;
          ba_addr_d = {tag_d, 1'b0} + (pick ? OFFSET1 : OFFSET0);
          discard_d = 1'b0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (clr) discard_d = 1'b1;
        if (ba_ack) begin
          ba_rd_d = 1'b0;
          // Simultaneous ack+rdy completes the fill in one step.
          if (ba_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (clr) discard_d = 1'b1;
        if (ba_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear seen at any point of the transaction voids its data.
  assign fill_keep = fill && !discard_q && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      tag_q     <= '0;
      ba_rd_q   <= 1'b0;
      ba_addr_q <= '0;
      ptr_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tag_q     <= tag_d;
      ba_rd_q   <= ba_rd_d;
      ba_addr_q <= ba_addr_d;
      ptr_q     <= ptr_d;
      discard_q <= discard_d;
    end
  end

  assign ba_rd   = ba_rd_q;
  assign ba_addr = ba_addr_q;

  jtframe_rd_line_cache #(
    .AW (AW)
  ) u_cache0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .addr      (slot0_addr),
    .cs        (slot0_cs),
    .fill      (fill_keep && !sel_q),
    .fill_tag  (tag_q),
    .fill_data (ba_dout),
    .hit       (hit0),
    .ok        (slot0_ok),
    .dout      (slot0_dout)
  );

  jtframe_rd_line_cache #(
    .AW (AW)
  ) u_cache1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .addr      (slot1_addr),
    .cs        (slot1_cs),
    .fill      (fill_keep && sel_q),
    .fill_tag  (tag_q),
    .fill_data (ba_dout),
    .hit       (hit1),
    .ok        (slot1_ok),
    .dout      (slot1_dout)
  );

endmodule
